disparity_select: RTL and testbench

//  Downstream of the window-sum accumulator. Takes the four per-candidate sums it emits
//  (g2sum, gsum, fg, place), one candidate per in_valid pulse.

---
 rtl/disparity_select.sv | 95 +++++++++
 tb/tb_disparity_select.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_select.sv
// Picks the lowest-cost candidate (cost = g2sum - 2*fg) out of each window of NCAND
// candidates, skipping low-texture ones, and holds the result until the consumer takes it.
module disparity_select #(
   parameter int          NCAND    = 4,
   parameter logic [10:0] MIN_GSUM = 11'd0,
   localparam int         CW       = (NCAND > 1) ? $clog2(NCAND) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [13:0]   g2sum,
   input  logic [10:0]   gsum,
   input  logic [13:0]   fg,
   input  logic [5:0]    place,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [5:0]    best_place,
   output logic [CW-1:0] best_idx,
   output logic [15:0]   best_cost,
   output logic          no_match,
   output logic          overrun
);

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t         state, state_next;
   logic [CW-1:0]  cnt;
   logic           found;
   logic           accept;
   logic           last;
   logic           eligible;
   logic           release_now;
   logic [11:0]    gsum_diff;
   logic [15:0]    cost;

   assign in_ready  = (state == COLLECT);
   assign out_valid = (state == HOLD);
   assign no_match  = out_valid & ~found;

   assign accept      = in_valid & in_ready & ~frame_start;
   assign last        = (cnt == CW'(NCAND - 1));
   assign release_now = frame_start | (out_valid & out_ready);

   // Borrow out of gsum - MIN_GSUM means gsum is below the texture threshold.
   assign gsum_diff = {1'b0, gsum} - {1'b0, MIN_GSUM};
   assign eligible  = ~gsum_diff[11];
   assign cost      = {2'b00, g2sum} - {1'b0, fg, 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= COLLECT;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         COLLECT: if (accept && last) state_next = HOLD;
         HOLD:    if (out_ready)      state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
      if (frame_start) state_next = COLLECT;
   end

   // Running best; strict less-than keeps the earliest index on a tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         found      <= 1'b0;
         best_place <= '0;
         best_idx   <= '0;
         best_cost  <= 16'h7FFF;
         overrun    <= 1'b0;
      end else begin
         if (in_valid && !in_ready && !frame_start) overrun <= 1'b1;
         if (release_now) begin
            cnt        <= '0;
            found      <= 1'b0;
            best_place <= '0;
            best_idx   <= '0;
            best_cost  <= 16'h7FFF;
         end else if (accept) begin
            cnt   <= last ? '0 : cnt + 1'b1;
            found <= found | eligible;
            if (eligible && ($signed(cost) < $signed(best_cost))) begin
               best_place <= place;
               best_idx   <= cnt;
               best_cost  <= cost;
            end
         end
      end
   end

endmodule

// File: tb/tb_disparity_select.sv
// Directed bench for disparity_select: two instances share stimulus, one with
// MIN_GSUM=0 and one with MIN_GSUM=10, checked against hand-computed results.
module tb_disparity_select;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start;
   logic        in_valid;
   logic [13:0] g2sum;
   logic [10:0] gsum;
   logic [13:0] fg;
   logic [5:0]  place;
   logic        out_ready;

   logic        in_ready0, out_valid0, no_match0, overrun0;
   logic [5:0]  best_place0;
   logic [1:0]  best_idx0;
   logic [15:0] best_cost0;
   logic        in_ready1, out_valid1, no_match1, overrun1;
   logic [5:0]  best_place1;
   logic [1:0]  best_idx1;
   logic [15:0] best_cost1;

   logic [25:0] res0, res1;
   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   assign res0 = {out_valid0, no_match0, best_place0, best_idx0, best_cost0};
   assign res1 = {out_valid1, no_match1, best_place1, best_idx1, best_cost1};

   disparity_select #(.NCAND(4), .MIN_GSUM(11'd0)) dut0 (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
      .in_ready(in_ready0), .g2sum(g2sum), .gsum(gsum), .fg(fg), .place(place),
      .out_valid(out_valid0), .out_ready(out_ready), .best_place(best_place0),
      .best_idx(best_idx0), .best_cost(best_cost0), .no_match(no_match0),
      .overrun(overrun0)
   );

   disparity_select #(.NCAND(4), .MIN_GSUM(11'd10)) dut1 (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
      .in_ready(in_ready1), .g2sum(g2sum), .gsum(gsum), .fg(fg), .place(place),
      .out_valid(out_valid1), .out_ready(out_ready), .best_place(best_place1),
      .best_idx(best_idx1), .best_cost(best_cost1), .no_match(no_match1),
      .overrun(overrun1)
   );

   task automatic send(input logic [13:0] g2, input logic [10:0] g,
                       input logic [13:0] f, input logic [5:0] p);
      in_valid = 1'b1;
      g2sum    = g2;
      gsum     = g;
      fg       = f;
      place    = p;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; frame_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      g2sum = '0; gsum = '0; fg = '0; place = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (res0 !== {1'b0, 1'b0, 6'd0, 2'd0, 16'h7FFF}) begin
         fails++; $display("[TB] FAIL reset_res0 got %h want %h", res0, {1'b0, 1'b0, 6'd0, 2'd0, 16'h7FFF});
      end
      checks++;
      if ({in_ready0, overrun0, in_ready1, overrun1} !== 4'b1010) begin
         fails++; $display("[TB] FAIL reset_flags got %b want 1010", {in_ready0, overrun0, in_ready1, overrun1});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      send(100, 20, 40, 3);
      send(90, 20, 50, 19);
      send(200, 30, 120, 35);
      checks++;
      if (out_valid0 !== 1'b0) begin
         fails++; $display("[TB] FAIL basic_early_valid got %b want 0", out_valid0);
      end
      send(50, 5, 10, 51);
      checks++;
      if (res0 !== {1'b1, 1'b0, 6'd35, 2'd2, 16'hFFD8}) begin
         fails++; $display("[TB] FAIL basic_res0 got %h want %h", res0, {1'b1, 1'b0, 6'd35, 2'd2, 16'hFFD8});
      end
      checks++;
      if (res1 !== {1'b1, 1'b0, 6'd35, 2'd2, 16'hFFD8}) begin
         fails++; $display("[TB] FAIL basic_res1 got %h want %h", res1, {1'b1, 1'b0, 6'd35, 2'd2, 16'hFFD8});
      end
      take();
      checks++;
      if ({out_valid0, in_ready0} !== 2'b01) begin
         fails++; $display("[TB] FAIL basic_release got %b want 01", {out_valid0, in_ready0});
      end
   endtask

   task automatic test_tie();
      send(50, 20, 10, 1);
      send(10, 20, 10, 2);
      send(40, 20, 10, 3);
      send(30, 20, 20, 4);
      checks++;
      if (res0 !== {1'b1, 1'b0, 6'd2, 2'd1, 16'hFFF6}) begin
         fails++; $display("[TB] FAIL tie_res0 got %h want %h", res0, {1'b1, 1'b0, 6'd2, 2'd1, 16'hFFF6});
      end
      take();
   endtask

   task automatic test_threshold();
      send(100, 9, 40, 3);
      send(90, 9, 50, 19);
      send(200, 9, 120, 35);
      send(50, 9, 10, 51);
      checks++;
      if (res1 !== {1'b1, 1'b1, 6'd0, 2'd0, 16'h7FFF}) begin
         fails++; $display("[TB] FAIL thresh_nomatch got %h want %h", res1, {1'b1, 1'b1, 6'd0, 2'd0, 16'h7FFF});
      end
      checks++;
      if (res0 !== {1'b1, 1'b0, 6'd35, 2'd2, 16'hFFD8}) begin
         fails++; $display("[TB] FAIL thresh_res0 got %h want %h", res0, {1'b1, 1'b0, 6'd35, 2'd2, 16'hFFD8});
      end
      take();
      send(100, 9, 40, 3);
      send(90, 12, 50, 19);
      send(200, 9, 120, 35);
      send(50, 9, 10, 51);
      checks++;
      if (res1 !== {1'b1, 1'b0, 6'd19, 2'd1, 16'hFFF6}) begin
         fails++; $display("[TB] FAIL thresh_single got %h want %h", res1, {1'b1, 1'b0, 6'd19, 2'd1, 16'hFFF6});
      end
      take();
   endtask

   task automatic test_backpressure();
      send(100, 20, 40, 3);
      send(90, 20, 50, 19);
      send(200, 30, 120, 35);
      send(50, 5, 10, 51);
      checks++;
      if (overrun0 !== 1'b0) begin
         fails++; $display("[TB] FAIL bp_overrun_pre got %b want 0", overrun0);
      end
      @(negedge clk);
      send(0, 20, 16383, 60);
      @(negedge clk);
      send(0, 20, 16383, 61);
      @(negedge clk);
      checks++;
      if (res0 !== {1'b1, 1'b0, 6'd35, 2'd2, 16'hFFD8}) begin
         fails++; $display("[TB] FAIL bp_frozen got %h want %h", res0, {1'b1, 1'b0, 6'd35, 2'd2, 16'hFFD8});
      end
      checks++;
      if ({overrun0, overrun1} !== 2'b11) begin
         fails++; $display("[TB] FAIL bp_overrun got %b want 11", {overrun0, overrun1});
      end
      take();
      send(10, 20, 0, 7);
      send(20, 20, 0, 8);
      send(30, 20, 0, 9);
      send(40, 20, 0, 10);
      checks++;
      if (res0 !== {1'b1, 1'b0, 6'd7, 2'd0, 16'd10}) begin
         fails++; $display("[TB] FAIL bp_next_window got %h want %h", res0, {1'b1, 1'b0, 6'd7, 2'd0, 16'd10});
      end
      checks++;
      if (overrun0 !== 1'b1) begin
         fails++; $display("[TB] FAIL bp_overrun_sticky got %b want 1", overrun0);
      end
      take();
   endtask

   task automatic test_frame_start_and_reset();
      send(0, 20, 1000, 1);
      send(0, 20, 1000, 2);
      frame_start = 1'b1;
      send(0, 20, 16383, 63);
      frame_start = 1'b0;
      send(10, 20, 0, 11);
      send(20, 20, 0, 12);
      send(30, 20, 0, 13);
      send(5, 20, 0, 14);
      checks++;
      if (res0 !== {1'b1, 1'b0, 6'd14, 2'd3, 16'd5}) begin
         fails++; $display("[TB] FAIL fs_fresh got %h want %h", res0, {1'b1, 1'b0, 6'd14, 2'd3, 16'd5});
      end
      take();
      send(0, 20, 1000, 5);
      send(0, 20, 1000, 6);
      rst_n = 1'b0;
      #1;
      checks++;
      if (res0 !== {1'b0, 1'b0, 6'd0, 2'd0, 16'h7FFF}) begin
         fails++; $display("[TB] FAIL midreset_res got %h want %h", res0, {1'b0, 1'b0, 6'd0, 2'd0, 16'h7FFF});
      end
      checks++;
      if ({in_ready0, overrun0} !== 2'b10) begin
         fails++; $display("[TB] FAIL midreset_flags got %b want 10", {in_ready0, overrun0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_extremes();
      send(0, 20, 16383, 1);
      send(16383, 20, 0, 2);
      send(16383, 20, 0, 3);
      send(16383, 20, 0, 4);
      checks++;
      if (res0 !== {1'b1, 1'b0, 6'd1, 2'd0, 16'h8002}) begin
         fails++; $display("[TB] FAIL ext_min got %h want %h", res0, {1'b1, 1'b0, 6'd1, 2'd0, 16'h8002});
      end
      take();
      send(16383, 20, 0, 5);
      send(16383, 20, 0, 6);
      send(16383, 20, 0, 7);
      send(16383, 20, 0, 8);
      checks++;
      if (res0 !== {1'b1, 1'b0, 6'd5, 2'd0, 16'h3FFF}) begin
         fails++; $display("[TB] FAIL ext_max got %h want %h", res0, {1'b1, 1'b0, 6'd5, 2'd0, 16'h3FFF});
      end
      take();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_threshold();
      test_backpressure();
      test_frame_start_and_reset();
      test_extremes();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
